// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the left-aligned PWM block.
package pwm_pkg;

    localparam int unsigned PWM_WIDTH = 32'd8;

    // Saturate a requested duty to the full-period value 2**width.
    function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned width);
        int unsigned full;
        full = 32'd1 << width;
        return (duty > full) ? full : duty;
    endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running period counter advanced by an enable tick; flags the wrapping tick.
module pwm_period_counter
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_cnt;

    // Advance on each enable tick; natural overflow gives the wrap to zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= {WIDTH{1'b0}};
        end else if (i_enable) begin
            r_cnt <= r_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = i_enable && (r_cnt == {WIDTH{1'b1}});

endmodule

// File: rtl/pwm_left_aligned.sv
// Left-aligned PWM: output high from period start for the shadowed duty count.
module pwm_left_aligned
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_enable,
    input  logic [WIDTH:0] i_duty_cycle,
    output logic           o_q,
    output logic           o_period_start
);

    logic [WIDTH-1:0] w_cnt;
    logic             w_wrap;
    logic [WIDTH:0]   w_duty_clamped;
    logic [WIDTH:0]   r_duty_act;
    logic             r_period_start;

    pwm_period_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .o_cnt    (w_cnt),
        .o_wrap   (w_wrap)
    );

    assign w_duty_clamped = (WIDTH+1)'(clamp_duty(32'(i_duty_cycle), WIDTH));

    // Duty is only sampled on the wrapping tick so a period never sees a partial pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_duty_act     <= {(WIDTH+1){1'b0}};
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_wrap;
            if (w_wrap) begin
                r_duty_act <= w_duty_clamped;
            end
        end
    end

    assign o_q            = ({1'b0, w_cnt} < r_duty_act);
    assign o_period_start = r_period_start;

endmodule

// File: tb/tb_pwm_left_aligned.sv
// Randomized self-checking bench for pwm_left_aligned against a tick-level period model.
module tb_pwm_left_aligned;

    localparam int W = 8;
    localparam int P = 256;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W:0]   dc;
    logic         q;
    logic         ps;

    int n_total = 0;
    int n_bad   = 0;

    // Model: position within the period, duty of the running period, duty of the previous one.
    int m_pos, m_duty, m_prev_duty;
    bit m_ps;
    int interval, phase;
    bit meas_valid;
    int hi_acc;

    always #5 clk = ~clk;

    pwm_left_aligned #(.WIDTH(W)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_enable       (en),
        .i_duty_cycle   (dc),
        .o_q            (q),
        .o_period_start (ps)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit r);
        rst = r;
        if (interval > 0) begin
            en    = (phase == interval - 1);
            phase = (phase + 1) % interval;
        end else begin
            en = ($urandom_range(0, 2) == 0);
        end
        @(posedge clk);
        if (r) begin
            m_pos = 0; m_duty = 0; m_ps = 0;
        end else if (en) begin
            m_ps = (m_pos == P - 1);
            if (m_ps) begin
                m_prev_duty = m_duty;
                m_duty      = (int'(dc) > P) ? P : int'(dc);
            end
            m_pos = (m_pos + 1) % P;
        end else begin
            m_ps = 0;
        end
        @(negedge clk);
        chk("q", 32'(q), 32'(m_pos < m_duty));
        chk("period_start", 32'(ps), 32'(m_ps));
        if (r) begin
            meas_valid = 0;
            hi_acc     = 0;
        end else if (m_ps) begin
            if (meas_valid) chk("high_time", hi_acc, m_prev_duty * interval);
            meas_valid = (interval > 0);
            hi_acc     = int'(q);
        end else begin
            hi_acc += int'(q);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic set_interval(input int iv);
        interval   = iv;
        phase      = 0;
        meas_valid = 0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dc = '0;
        m_pos = 0; m_duty = 0; m_prev_duty = 0; m_ps = 0; hi_acc = 0;
        set_interval(16);
        step(1'b1);
        step(1'b1);
        chk("reset_q", 32'(q), 32'd0);
        chk("reset_period_start", 32'(ps), 32'd0);

        // Duty zero, then small, mid-range and full-scale duties at tick/16.
        dc = 9'd0;   run(3 * 4096 + 16);
        dc = 9'd1;   run(2 * 4096);
        dc = 9'd64;  run(2 * 4096);
        run(1500);
        dc = 9'd128; run(2 * 4096);
        dc = 9'd255; run(2 * 4096);
        dc = 9'd256; run(2 * 4096);
        chk("full_duty_q", 32'(q), 32'd1);
        dc = 9'd300; run(2 * 4096);
        chk("clamped_duty_q", 32'(q), 32'd1);

        // Enable held high continuously.
        set_interval(1);
        dc = 9'd3; run(4 * 256 + 8);

        // Reset asserted while q is high, then recovery.
        set_interval(16);
        dc = 9'd128;
        for (int i = 0; i < 3 * 4096 && !(m_duty > 0 && m_pos > 10 && m_pos < m_duty); i++) step(1'b0);
        chk("q_high_before_reset", 32'(q), 32'd1);
        step(1'b1);
        chk("q_after_mid_reset", 32'(q), 32'd0);
        run(2 * 4096 + 32);

        // Random duties, random enable pattern, occasional reset.
        set_interval(0);
        for (int k = 0; k < 40; k++) begin
            dc = 9'($urandom_range(0, 300));
            run($urandom_range(50, 250));
            if ($urandom_range(0, 9) == 0) step(1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_left_aligned.md
Name: pwm_left_aligned

Overview:
- Left-aligned (edge-aligned) pulse-width modulator. A free-running WIDTH-bit period counter advances only on an external `enable` tick (prescaler strobe).
- Output `q` goes high at the start of every period and stays high for `duty_cycle` ticks.
- Sits between a system prescaler/tick generator and a pin driver (LED, motor, DAC filter).

Parameters:
- WIDTH, 8, period counter width; period = 2**WIDTH enable ticks; duty range 0..2**WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  tick strobe; counter advances only on clk edges where enable=1. May be held high continuously.
- duty_cycle  input  WIDTH+1  requested high time in ticks, 0..2**WIDTH; larger values are clamped to 2**WIDTH.
- q  output  1  PWM output.
- period_start  output  1  one-clk pulse on the edge where the counter wraps and a new duty is loaded.

Behaviour:
- State:
  - cnt[WIDTH-1:0] period counter.
  - duty_act[WIDTH:0] active (shadow) duty.
- Reset (reset=1 at a clk edge; overrides enable):
  - cnt=0, duty_act=0, period_start=0.
  - Hence q=0.
  - Applies equally when asserted mid-period.
- Counting:
  - On each clk edge with enable=1 and reset=0: cnt <= cnt+1, unsigned, wrapping 2**WIDTH-1 -> 0.
  - With enable=0, cnt and duty_act hold.
- Duty shadowing (glitch-free update):
  - On an edge with enable=1 and cnt==2**WIDTH-1, duty_act <= min(duty_cycle, 2**WIDTH).
  - Changes to duty_cycle mid-period take effect only at the next period start.
  - After reset, the first period runs with duty_act=0 (q low) until the first wrap.
- Output:
  - q = ({1'b0,cnt} < duty_act).
  - Combinational from registers only; no combinational path from duty_cycle or enable to q.
- Output cases:
  - duty_act=0 -> q constantly 0.
  - duty_act=2**WIDTH -> q constantly 1, no low gap.
  - duty_act=2**WIDTH-1 -> one low tick per period.
  - duty_act=N -> q high while cnt in 0..N-1, i.e. N*(enable period) clocks.
- period_start: registered; 1 for exactly one clk after the loading edge, i.e. aligned with cnt becoming 0. Otherwise 0.
- Latency: new duty visible on q on the first clk after the wrap edge.

Decomposition:
- Shared package pwm_pkg:
  - Constant PWM_WIDTH=8.
  - Function clamp_duty (saturate WIDTH+1-bit value to 2**WIDTH).
- Sub-module pwm_period_counter:
  - Counter with enable and wrap flag output.
  - Instantiated once; the compare/shadow logic stays in the top.

Test Plan:
- Setup for all scenarios: enable pulses 1 clk in every 16 (tick every 16 clks, period 4096 clks), reset pulsed at start.
1. After reset, duty_cycle=0 -> q stays 0 for ≥3 periods; period_start pulses every 4096 clks.
2. duty_cycle=1 -> from next period, q high 16 clks, low 4080 clks, each period; rises with period_start.
3. duty_cycle=64 then 128 -> q high 1024 then 2048 clks. The switch occurs exactly at a period boundary, with no partial pulse even if duty changes mid-period.
4. duty_cycle=255 -> high 4080, low 16. duty_cycle=256 -> q constantly 1 across boundaries. duty_cycle=300 -> same as 256 (clamp).
5. enable held high continuously, WIDTH=8, duty_cycle=3 -> q high 3 clks of every 256.
6. Assert reset mid-period with q high -> q=0 and cnt=0 on the next clk. After release, the first period is low, then normal duty resumes.
